// File: rtl/rv_timer_nch_pkg.sv
// rv_timer_nch_pkg
// Shared definitions for the multi-channel machine timer: register byte
// offsets, channel window layout, channel limit and the per-channel
// configuration record used for readback.
package rv_timer_nch_pkg;

  localparam int MaxChannels = 16;

  // Global register byte offsets
  localparam logic [9:0] OffCtrl       = 10'h000;
  localparam logic [9:0] OffCfg        = 10'h004;
  localparam logic [9:0] OffTimerLo    = 10'h008;
  localparam logic [9:0] OffTimerHi    = 10'h00C;
  localparam logic [9:0] OffIntrEnable = 10'h010;
  localparam logic [9:0] OffIntrState  = 10'h014;
  localparam logic [9:0] OffIntrTest   = 10'h018;
  localparam logic [9:0] OffMode       = 10'h01C;

  // Channel windows: channel i starts at ChanBase + ChanStride*i
  localparam logic [9:0] ChanBase   = 10'h040;
  localparam logic [9:0] ChanStride = 10'h010;

  // Offsets inside one channel window
  localparam logic [3:0] ChanOffCmpLo  = 4'h0;
  localparam logic [3:0] ChanOffCmpHi  = 4'h4;
  localparam logic [3:0] ChanOffPeriod = 4'h8;

  // Per-channel configuration as seen by the register readback.
  // cmp is always 64 bits wide; unused upper bits are zero.
  typedef struct packed {
    logic [63:0] cmp;
    logic [31:0] period;
    logic        periodic;
    logic        enable;
  } chan_cfg_t;

endpackage

// File: rtl/rv_timer_nch_chan.sv
// rv_timer_nch_chan
// One timer comparator channel: CMP/PERIOD registers, magnitude compare
// against mtime, periodic auto-advance and interrupt state arbitration.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   mtime_i              shared counter value
//   wdata_i              register write data
//   cmp_lo_we_i          write CMP[31:0]
//   cmp_hi_we_i          write CMP[CW-1:32]
//   period_we_i          write PERIOD
//   enable_we_i/_bit_i   write interrupt enable bit
//   mode_we_i/_bit_i     write periodic-mode bit
//   w1c_i                clear state (write-1-to-clear)
//   test_i               set state (interrupt test)
//   cfg_o                configuration for readback
//   state_o              interrupt state
//   intr_o               masked interrupt
module rv_timer_nch_chan
  import rv_timer_nch_pkg::*;
#(
  parameter int CounterWidth = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [CounterWidth-1:0] mtime_i,
  input  logic [31:0]             wdata_i,
  input  logic                    cmp_lo_we_i,
  input  logic                    cmp_hi_we_i,
  input  logic                    period_we_i,
  input  logic                    enable_we_i,
  input  logic                    enable_bit_i,
  input  logic                    mode_we_i,
  input  logic                    mode_bit_i,
  input  logic                    w1c_i,
  input  logic                    test_i,
  output chan_cfg_t               cfg_o,
  output logic                    state_o,
  output logic                    intr_o
);

  localparam int CW = CounterWidth;

  logic [CW-1:0] cmp_q, cmp_d;
  logic [31:0]   period_q, period_d;
  logic          enable_q, enable_d;
  logic          periodic_q, periodic_d;
  logic          state_q, state_d;
  logic          hit;
  logic          advance;
  logic          unused_wdata;

  // Upper write-data bits are dropped when CounterWidth < 64
  assign unused_wdata = ^wdata_i;

  // Magnitude compare so a step larger than 1 cannot jump over cmp
  assign hit     = (mtime_i >= cmp_q);
  assign advance = hit && periodic_q && (period_q != 32'd0);

  always_comb begin
    cmp_d      = cmp_q;
    period_d   = period_q;
    enable_d   = enable_q;
    periodic_d = periodic_q;

    if (advance) begin
      cmp_d = cmp_q + CW'(period_q);
    end
    // Software writes take priority over the hardware advance
    if (cmp_lo_we_i) begin
      cmp_d = {cmp_q[CW-1:32], wdata_i};
    end
    if (cmp_hi_we_i) begin
      cmp_d = {wdata_i[CW-33:0], cmp_q[31:0]};
    end
    if (period_we_i) begin
      period_d = wdata_i;
    end
    if (enable_we_i) begin
      enable_d = enable_bit_i;
    end
    if (mode_we_i) begin
      periodic_d = mode_bit_i;
    end

    // Hardware set and test both dominate a simultaneous clear
    state_d = (state_q & ~w1c_i) | hit | test_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmp_q      <= '1;
      period_q   <= '0;
      enable_q   <= 1'b0;
      periodic_q <= 1'b0;
      state_q    <= 1'b0;
    end else begin
      cmp_q      <= cmp_d;
      period_q   <= period_d;
      enable_q   <= enable_d;
      periodic_q <= periodic_d;
      state_q    <= state_d;
    end
  end

  assign cfg_o.cmp      = 64'(cmp_q);
  assign cfg_o.period   = period_q;
  assign cfg_o.periodic = periodic_q;
  assign cfg_o.enable   = enable_q;

  assign state_o = state_q;
  assign intr_o  = state_q & enable_q;

endmodule

// File: rtl/rv_timer_nch.sv
// rv_timer_nch
// Multi-channel RISC-V machine timer: shared prescaled counter (mtime)
// advanced by a programmable step, NumChannels comparator channels and a
// 32-bit register port with one-cycle registered response.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   reg_req_i       access request (one-cycle pulse)
//   reg_we_i        1 = write, 0 = read
//   reg_addr_i      byte address; bits [1:0] ignored
//   reg_wdata_i     write data
//   reg_rvalid_o    response valid, one cycle after the request
//   reg_rdata_o     read data (0 for writes and unmapped addresses)
//   reg_err_o       unmapped address
//   intr_o          per-channel level interrupt
module rv_timer_nch
  import rv_timer_nch_pkg::*;
#(
  parameter int NumChannels   = 4,
  parameter int CounterWidth  = 64,
  parameter int PrescaleWidth = 12,
  parameter int StepWidth     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   reg_req_i,
  input  logic                   reg_we_i,
  input  logic [9:0]             reg_addr_i,
  input  logic [31:0]            reg_wdata_i,
  output logic                   reg_rvalid_o,
  output logic [31:0]            reg_rdata_o,
  output logic                   reg_err_o,
  output logic [NumChannels-1:0] intr_o
);

  localparam int CW = CounterWidth;
  localparam int PW = PrescaleWidth;
  localparam int SW = StepWidth;

  // Counter and control state
  logic          active_q, active_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic [SW-1:0] step_q, step_d;
  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  logic [CW-1:0] mtime_q, mtime_d;
  logic          tick;

  // Response registers
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Decode
  logic [9:0] addr_a;
  logic [9:0] rel_a;
  logic [5:0] ch_sel;
  logic [3:0] ch_off;
  logic       is_glob, is_chan, mapped;
  logic       wr;
  logic       unused_addr;

  // Channel-facing signals
  chan_cfg_t              chan_cfg [NumChannels];
  logic [MaxChannels-1:0] state_vec, enable_vec, mode_vec;
  logic [31:0]            cfg_rd, rd_data;

  assign unused_addr = ^reg_addr_i[1:0];

  assign addr_a  = {reg_addr_i[9:2], 2'b00};
  assign rel_a   = addr_a - ChanBase;
  assign ch_sel  = rel_a[9:4];
  assign ch_off  = rel_a[3:0];
  assign is_glob = (addr_a <= OffMode);
  assign is_chan = (addr_a >= ChanBase)
                && ({22'd0, rel_a} < 32'(ChanStride) * 32'(NumChannels))
                && (ch_off != 4'hC);
  assign mapped  = is_glob | is_chan;
  assign wr      = reg_req_i & reg_we_i;

  // ---------------------------------------------------------------------
  // Prescaler, mtime and global control registers
  // ---------------------------------------------------------------------
  always_comb begin
    active_d    = active_q;
    prescale_d  = prescale_q;
    step_d      = step_q;
    presc_cnt_d = presc_cnt_q;
    mtime_d     = mtime_q;
    tick        = 1'b0;

    if (active_q) begin
      // >= rather than == so that lowering prescale below the running
      // count wraps at once instead of running through the full range
      if (presc_cnt_q >= prescale_q) begin
        presc_cnt_d = '0;
        tick        = 1'b1;
      end else begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end
    end

    if (tick) begin
      mtime_d = mtime_q + CW'(step_q);
    end

    // A timer write replaces the whole increment of this cycle
    if (wr && addr_a == OffTimerLo) begin
      mtime_d = {mtime_q[CW-1:32], reg_wdata_i};
    end
    if (wr && addr_a == OffTimerHi) begin
      mtime_d = {reg_wdata_i[CW-33:0], mtime_q[31:0]};
    end
    if (wr && addr_a == OffCtrl) begin
      active_d = reg_wdata_i[0];
    end
    if (wr && addr_a == OffCfg) begin
      prescale_d = reg_wdata_i[PW-1:0];
      step_d     = reg_wdata_i[16 +: SW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q    <= 1'b0;
      prescale_q  <= '0;
      step_q      <= SW'(1);
      presc_cnt_q <= '0;
      mtime_q     <= '0;
    end else begin
      active_q    <= active_d;
      prescale_q  <= prescale_d;
      step_q      <= step_d;
      presc_cnt_q <= presc_cnt_d;
      mtime_q     <= mtime_d;
    end
  end

  // ---------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < MaxChannels; gi++) begin : g_chan
    if (gi < NumChannels) begin : g_used
      logic sel;
      assign sel = wr & is_chan & (ch_sel == 6'(gi));

      rv_timer_nch_chan #(
        .CounterWidth(CW)
      ) u_chan (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .mtime_i     (mtime_q),
        .wdata_i     (reg_wdata_i),
        .cmp_lo_we_i (sel & (ch_off == ChanOffCmpLo)),
        .cmp_hi_we_i (sel & (ch_off == ChanOffCmpHi)),
        .period_we_i (sel & (ch_off == ChanOffPeriod)),
        .enable_we_i (wr & (addr_a == OffIntrEnable)),
        .enable_bit_i(reg_wdata_i[gi]),
        .mode_we_i   (wr & (addr_a == OffMode)),
        .mode_bit_i  (reg_wdata_i[gi]),
        .w1c_i       (wr & (addr_a == OffIntrState) & reg_wdata_i[gi]),
        .test_i      (wr & (addr_a == OffIntrTest) & reg_wdata_i[gi]),
        .cfg_o       (chan_cfg[gi]),
        .state_o     (state_vec[gi]),
        .intr_o      (intr_o[gi])
      );

      assign enable_vec[gi] = chan_cfg[gi].enable;
      assign mode_vec[gi]   = chan_cfg[gi].periodic;
    end else begin : g_pad
      assign state_vec[gi]  = 1'b0;
      assign enable_vec[gi] = 1'b0;
      assign mode_vec[gi]   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Readback and response
  // ---------------------------------------------------------------------
  always_comb begin
    cfg_rd            = '0;
    cfg_rd[PW-1:0]    = prescale_q;
    cfg_rd[16 +: SW]  = step_q;
  end

  always_comb begin
    rd_data = '0;
    case (addr_a)
      OffCtrl:       rd_data = {31'd0, active_q};
      OffCfg:        rd_data = cfg_rd;
      OffTimerLo:    rd_data = mtime_q[31:0];
      OffTimerHi:    rd_data = 32'(mtime_q[CW-1:32]);
      OffIntrEnable: rd_data = 32'(enable_vec);
      OffIntrState:  rd_data = 32'(state_vec);
      OffIntrTest:   rd_data = '0;
      OffMode:       rd_data = 32'(mode_vec);
      default: begin
        for (int i = 0; i < NumChannels; i++) begin
          if (is_chan && ch_sel == 6'(i)) begin
            case (ch_off)
              ChanOffCmpLo:  rd_data = chan_cfg[i].cmp[31:0];
              ChanOffCmpHi:  rd_data = chan_cfg[i].cmp[63:32];
              ChanOffPeriod: rd_data = chan_cfg[i].period;
              default:       rd_data = '0;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    rdata_d = (reg_req_i && !reg_we_i && mapped) ? rd_data : 32'd0;
    err_d   = reg_req_i & ~mapped;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= reg_req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign reg_rvalid_o = rvalid_q;
  assign reg_rdata_o  = rdata_q;
  assign reg_err_o    = err_q;

endmodule

// File: tb/tb_rv_timer_nch.sv
// Directed testbench for rv_timer_nch (4 channels, 64-bit counter).
module tb_rv_timer_nch;

  logic        clk;
  logic        rst_n;
  logic        reg_req;
  logic        reg_we;
  logic [9:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [3:0]  intr;

  int n_vec;
  int n_err;

  logic [31:0] rd_d;
  logic        rd_e;

  rv_timer_nch #(
    .NumChannels  (4),
    .CounterWidth (64),
    .PrescaleWidth(12),
    .StepWidth    (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .reg_req_i   (reg_req),
    .reg_we_i    (reg_we),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_rvalid_o(rvalid),
    .reg_rdata_o (rdata),
    .reg_err_o   (err),
    .intr_o      (intr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One-cycle write; caller is at a negedge, returns at the next negedge
  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    reg_req   = 1'b1;
    reg_we    = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk);
    $display("write addr=0x%03h data=0x%08h rvalid=%0d", a, d, rvalid);
    reg_req = 1'b0;
    reg_we  = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, output logic [31:0] d, output logic e);
    reg_req  = 1'b1;
    reg_we   = 1'b0;
    reg_addr = a;
    @(negedge clk);
    d = rdata;
    e = err;
    $display("read  addr=0x%03h data=0x%08h err=%0d", a, d, e);
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
    reg_req = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    rd(a, d, e);
    chk(tag, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    reg_req   = 1'b0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;

    // Reset state
    #12;
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_intr", {28'd0, intr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    rdchk("rst_cfg", 10'h004, 32'h0001_0000);
    rdchk("rst_cmp0_hi", 10'h044, 32'hFFFF_FFFF);
    rdchk("rst_cmp3_lo", 10'h070, 32'hFFFF_FFFF);
    rdchk("rst_period3", 10'h078, 32'h0);

    // Prescale 3, step 1: 5 ticks in 20 active cycles, then frozen
    wr(10'h004, 32'h0001_0003);
    wr(10'h000, 32'h1);
    idle(20);
    wr(10'h000, 32'h0);
    idle(3);
    rdchk("presc_mtime", 10'h008, 32'd5);
    idle(4);
    rdchk("frozen_mtime", 10'h008, 32'd5);

    // Step 4, CMP0 = 10: interrupt the cycle after mtime = 12
    wr(10'h004, 32'h0004_0000);
    wr(10'h008, 32'h0);
    wr(10'h044, 32'h0);
    wr(10'h040, 32'd10);
    wr(10'h010, 32'h1);
    chk("intr_before", {28'd0, intr}, 32'h0);
    wr(10'h000, 32'h1);
    idle(3);
    chk("intr_at_12", {28'd0, intr}, 32'h0);
    idle(1);
    chk("intr_rise", {28'd0, intr}, 32'h1);
    wr(10'h000, 32'h0);
    rdchk("step_mtime", 10'h008, 32'd20);

    // W1C while hit persists: state stays set
    wr(10'h014, 32'h1);
    rdchk("w1c_vs_hit", 10'h014, 32'h1);
    chk("w1c_vs_hit_intr", {28'd0, intr}, 32'h1);
    wr(10'h044, 32'hFFFF_FFFF);
    wr(10'h014, 32'h1);
    rdchk("w1c_clear", 10'h014, 32'h0);
    chk("w1c_clear_intr", {28'd0, intr}, 32'h0);

    // Channel 1 periodic, CMP 100, PERIOD 50
    wr(10'h01C, 32'h2);
    wr(10'h054, 32'h0);
    wr(10'h050, 32'd100);
    wr(10'h058, 32'd50);
    rdchk("per_period", 10'h058, 32'd50);
    wr(10'h008, 32'd99);
    idle(1);
    rdchk("per_before", 10'h014, 32'h0);
    wr(10'h008, 32'd100);
    idle(1);
    rdchk("per_hit100", 10'h014, 32'h2);
    rdchk("per_cmp150", 10'h050, 32'd150);
    wr(10'h014, 32'h2);
    rdchk("per_clr100", 10'h014, 32'h0);
    wr(10'h008, 32'd150);
    idle(1);
    rdchk("per_hit150", 10'h014, 32'h2);
    rdchk("per_cmp200", 10'h050, 32'd200);
    wr(10'h014, 32'h2);
    rdchk("per_clr150", 10'h014, 32'h0);
    wr(10'h008, 32'd200);
    idle(1);
    rdchk("per_hit200", 10'h014, 32'h2);
    rdchk("per_cmp250", 10'h050, 32'd250);
    wr(10'h014, 32'h2);
    rdchk("per_clr200", 10'h014, 32'h0);

    // CMP write on the same edge as a periodic advance
    wr(10'h008, 32'd1000);
    wr(10'h050, 32'd5000);
    rdchk("sw_wins_cmp", 10'h050, 32'd5000);
    wr(10'h014, 32'h2);
    rdchk("sw_wins_clr", 10'h014, 32'h0);

    // Wrap-around with step 4
    wr(10'h01C, 32'h0);
    wr(10'h00C, 32'hFFFF_FFFF);
    wr(10'h008, 32'hFFFF_FFFF);
    idle(1);
    rdchk("wrap_allones", 10'h014, 32'hF);
    wr(10'h008, 32'hFFFF_FFFE);
    wr(10'h014, 32'hC);
    rdchk("wrap_below", 10'h014, 32'h3);
    wr(10'h000, 32'h1);
    wr(10'h000, 32'h0);
    rdchk("wrap_lo", 10'h008, 32'd2);
    rdchk("wrap_hi", 10'h00C, 32'd0);
    wr(10'h014, 32'hF);
    rdchk("wrap_nohit", 10'h014, 32'h0);

    // Unmapped addresses
    rd(10'h080, rd_d, rd_e);
    chk("unmap_ch4_err", {31'd0, rd_e}, 32'd1);
    chk("unmap_ch4_data", rd_d, 32'd0);
    rd(10'h04C, rd_d, rd_e);
    chk("unmap_off_err", {31'd0, rd_e}, 32'd1);
    rd(10'h020, rd_d, rd_e);
    chk("unmap_gap_err", {31'd0, rd_e}, 32'd1);
    rd(10'h01C, rd_d, rd_e);
    chk("mapped_err", {31'd0, rd_e}, 32'd0);

    // INTR_TEST with enables off
    wr(10'h010, 32'h0);
    wr(10'h018, 32'h5);
    chk("test_intr_masked", {28'd0, intr}, 32'h0);
    rdchk("test_state", 10'h014, 32'h5);
    rdchk("test_reads0", 10'h018, 32'h0);
    wr(10'h010, 32'h1);
    chk("test_intr_en", {28'd0, intr}, 32'h1);

    // Reset in the middle of an outstanding read response
    reg_req  = 1'b1;
    reg_we   = 1'b0;
    reg_addr = 10'h014;
    @(posedge clk);
    #2;
    chk("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
    chk("pre_rst_rdata", rdata, 32'h5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_intr", {28'd0, intr}, 32'd0);
    reg_req = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    rdchk("post_rst_cmp0", 10'h040, 32'hFFFF_FFFF);
    rdchk("post_rst_state", 10'h014, 32'h0);
    rdchk("post_rst_mtime", 10'h008, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
